// File: rtl/button_debouncer_pkg.sv
// Shared FSM encodings and helpers for the calculator front-end blocks.
// Holds the debounce channel state encoding used by debounce_cell.
package button_debouncer_pkg;

    // Bit 1 is the accepted level; the WAIT states differ from IDLE in bit 0 vs bit 1.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } debounce_state_e;

    function automatic logic is_wait(input debounce_state_e state);
        return (state == WAIT_HIGH) || (state == WAIT_LOW);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button pins in, debounced levels and busy flag out.
// The master side is the button source; the slave side is the debouncer.
interface button_debouncer_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_level;
    logic               btn_busy;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_busy
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_busy
    );
endinterface

// File: rtl/button_debouncer_cell.sv
// One debounce channel: 2-flop synchronizer, 4-state FSM and stability counter.
// The level is accepted after DEBOUNCE_CYCLES+1 consecutive differing samples.
module debounce_cell
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic waiting
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             sync;
    debounce_state_e  state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn};
        end
    end

    assign sync = sync_reg[1];

    // A reversal in either WAIT state drops back to IDLE, so partial counts never survive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE_LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE_LOW: begin
                    if (sync) begin
                        state_reg <= WAIT_HIGH;
                        cnt_reg   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync) begin
                        state_reg <= IDLE_LOW;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= IDLE_HIGH;
                        cnt_reg   <= '0;
                        level_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync) begin
                        state_reg <= WAIT_LOW;
                        cnt_reg   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync) begin
                        state_reg <= IDLE_HIGH;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= IDLE_LOW;
                        cnt_reg   <= '0;
                        level_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE_LOW;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end
            endcase
        end
    end

    assign level   = level_reg;
    assign waiting = is_wait(state_reg);

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: one debounce_cell per pin plus a
// registered busy flag that is high while any channel has a change pending.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input logic               clk,
    input logic               rst,
    button_debouncer_if.slave bus
);

    logic [NUM_BTN-1:0] wait_vec;
    logic               busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .btn    (bus.btn_in[gi]),
                .level  (bus.btn_level[gi]),
                .waiting(wait_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= |wait_vec;
        end
    end

    assign bus.btn_busy = busy_reg;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing, all
// compared against a run-length reference model of the debounce rule.
module tb_button_debouncer;

    localparam int NB = 5;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    button_debouncer_if #(.NUM_BTN(NB)) bus ();

    button_debouncer #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: level flips after D+1 consecutive synchronized samples that disagree with it.
    logic [NB-1:0] m_s1, m_s2, m_level;
    logic          m_busy;
    int            m_run[NB];

    task automatic model_reset();
        m_s1    = '0;
        m_s2    = '0;
        m_level = '0;
        m_busy  = 1'b0;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic any;
        if (!rst) begin
            model_reset();
            return;
        end
        any = 1'b0;
        for (int i = 0; i < NB; i++) if (m_run[i] > 0) any = 1'b1;
        m_busy = any;
        for (int i = 0; i < NB; i++) begin
            if (m_s2[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    m_level[i] = ~m_level[i];
                    m_run[i]   = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = bus.btn_in;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.btn_in = '0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.btn_level !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_level got=%b exp=%b", bus.btn_level, 5'b00000);
        end
        n_tests++;
        if (bus.btn_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got=%b exp=0", bus.btn_busy);
        end
        rst = 1'b1;
        step();
        $display("[TB] reset done level=%b busy=%b", bus.btn_level, bus.btn_busy);
    endtask

    task automatic test_clean_press();
        bus.btn_in[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_tests++;
            if (bus.btn_level[0] !== (k >= 11)) begin
                n_fail++;
                $display("FAIL press_level0 edge=%0d got=%b exp=%b", k, bus.btn_level[0], (k >= 11));
            end
            n_tests++;
            if (bus.btn_busy !== (k >= 4 && k <= 11)) begin
                n_fail++;
                $display("FAIL press_busy edge=%0d got=%b exp=%b", k, bus.btn_busy, (k >= 4 && k <= 11));
            end
            n_tests++;
            if (bus.btn_level !== m_level || bus.btn_busy !== m_busy) begin
                n_fail++;
                $display("FAIL press_model edge=%0d got=%b/%b exp=%b/%b", k, bus.btn_level, bus.btn_busy, m_level, m_busy);
            end
        end
        $display("[TB] clean press level=%b", bus.btn_level);
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 32; t++) begin
            if (t <= 18 && (t % 3) == 0) bus.btn_in[1] = ~bus.btn_in[1];
            step();
            n_tests++;
            if (bus.btn_level[1] !== (t >= 28)) begin
                n_fail++;
                $display("FAIL bounce_level1 t=%0d got=%b exp=%b", t, bus.btn_level[1], (t >= 28));
            end
            n_tests++;
            if (bus.btn_level !== m_level || bus.btn_busy !== m_busy) begin
                n_fail++;
                $display("FAIL bounce_model t=%0d got=%b/%b exp=%b/%b", t, bus.btn_level, bus.btn_busy, m_level, m_busy);
            end
        end
        $display("[TB] bounce level=%b", bus.btn_level);
    endtask

    task automatic test_glitch();
        for (int t = 0; t < 22; t++) begin
            bus.btn_in[2] = (t < 7);
            step();
            n_tests++;
            if (bus.btn_level[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_level2 t=%0d got=%b exp=0", t, bus.btn_level[2]);
            end
        end
        n_tests++;
        if (bus.btn_busy !== 1'b0 || bus.btn_busy !== m_busy) begin
            n_fail++;
            $display("FAIL glitch_busy got=%b exp=0 model=%b", bus.btn_busy, m_busy);
        end
        $display("[TB] glitch level=%b busy=%b", bus.btn_level, bus.btn_busy);
    endtask

    task automatic test_release();
        bus.btn_in[3] = 1'b1;
        repeat (12) step();
        n_tests++;
        if (bus.btn_level !== 5'b01011) begin
            n_fail++;
            $display("FAIL release_setup got=%b exp=%b", bus.btn_level, 5'b01011);
        end
        bus.btn_in[3] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_tests++;
            if (bus.btn_level !== ((k >= 11) ? 5'b00011 : 5'b01011)) begin
                n_fail++;
                $display("FAIL release_level edge=%0d got=%b exp=%b", k, bus.btn_level, ((k >= 11) ? 5'b00011 : 5'b01011));
            end
            n_tests++;
            if (bus.btn_level !== m_level || bus.btn_busy !== m_busy) begin
                n_fail++;
                $display("FAIL release_model edge=%0d got=%b/%b exp=%b/%b", k, bus.btn_level, bus.btn_busy, m_level, m_busy);
            end
        end
        $display("[TB] release level=%b", bus.btn_level);
    endtask

    task automatic test_reset_mid();
        bus.btn_in = 5'b10000;
        repeat (8) step();
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (bus.btn_level !== 5'b00000 || bus.btn_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear got=%b/%b exp=00000/0", bus.btn_level, bus.btn_busy);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.btn_level !== 5'b00000) begin
            n_fail++;
            $display("FAIL rstmid_hold got=%b exp=00000", bus.btn_level);
        end
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_tests++;
            if (bus.btn_level !== ((k >= 11) ? 5'b10000 : 5'b00000)) begin
                n_fail++;
                $display("FAIL rstmid_level edge=%0d got=%b exp=%b", k, bus.btn_level, ((k >= 11) ? 5'b10000 : 5'b00000));
            end
            n_tests++;
            if (bus.btn_level !== m_level || bus.btn_busy !== m_busy) begin
                n_fail++;
                $display("FAIL rstmid_model edge=%0d got=%b/%b exp=%b/%b", k, bus.btn_level, bus.btn_busy, m_level, m_busy);
            end
        end
        $display("[TB] reset mid-count level=%b", bus.btn_level);
    endtask

    task automatic test_simultaneous();
        bus.btn_in = '0;
        repeat (14) step();
        n_tests++;
        if (bus.btn_level !== 5'b00000) begin
            n_fail++;
            $display("FAIL simul_setup got=%b exp=00000", bus.btn_level);
        end
        bus.btn_in = 5'b10101;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_tests++;
            if (bus.btn_level !== ((k >= 11) ? 5'b10101 : 5'b00000)) begin
                n_fail++;
                $display("FAIL simul_level edge=%0d got=%b exp=%b", k, bus.btn_level, ((k >= 11) ? 5'b10101 : 5'b00000));
            end
        end
        $display("[TB] simultaneous level=%b", bus.btn_level);
    endtask

    task automatic test_random();
        int hold[NB];
        int errs;
        errs = 0;
        for (int i = 0; i < NB; i++) hold[i] = $urandom_range(14, 1);
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < NB; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    bus.btn_in[i] = ~bus.btn_in[i];
                    hold[i] = $urandom_range(14, 1);
                end
            end
            step();
            n_tests++;
            if (bus.btn_level !== m_level || bus.btn_busy !== m_busy) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_model t=%0d got=%b/%b exp=%b/%b", t, bus.btn_level, bus.btn_busy, m_level, m_busy);
            end
        end
        $display("[TB] random run done level=%b", bus.btn_level);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
